// File: rtl/zap_mode16_seq_pkg.sv
// ---------------------------------------------------------------------------
// zap_mode16_seq_pkg
//
// Shared types for the compressed-mode halfword sequencer.
//   seq_state_t   : buffer occupancy (empty / lower-or-whole next / upper next)
//   seq_entry_t   : one buffered fetch word with its address and attributes
//   HALFWORD_W    : width of a compressed instruction
//   SEQ_PC_W      : address width held inside a buffered entry
// ---------------------------------------------------------------------------
package zap_mode16_seq_pkg;

    localparam int HALFWORD_W = 16;
    localparam int WORD_W     = 32;
    localparam int SEQ_PC_W   = 32;

    // ST_LO : next issue is the lower halfword (T) or the whole word (ARM).
    // ST_HI : next issue is the upper halfword.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]   word;
        logic [SEQ_PC_W-1:0] pc;
        logic                t;
        logic                abort;
    } seq_entry_t;

endpackage

// File: rtl/zap_mode16_hw_select.sv
// ---------------------------------------------------------------------------
// zap_mode16_hw_select
//
// Combinational view of one buffered entry as a decoder-ready instruction.
// In compressed mode the selected halfword is zero-extended and the address
// is rebuilt from the word address plus the half select; in 32-bit mode the
// word and address pass straight through. An aborted entry always presents
// a zero instruction so garbage never reaches the decoder.
//
// Ports:
//   i_entry       in   buffered word, pc, T bit, abort
//   i_sel_upper   in   1 = take bits [31:16] (ignored in 32-bit mode)
//   o_instruction out  instruction to issue
//   o_pc          out  address of that instruction
//   o_upper       out  issued halfword came from the upper half
// ---------------------------------------------------------------------------
module zap_mode16_hw_select
    import zap_mode16_seq_pkg::*;
(
    input  seq_entry_t          i_entry,
    input  logic                i_sel_upper,
    output logic [WORD_W-1:0]   o_instruction,
    output logic [SEQ_PC_W-1:0] o_pc,
    output logic                o_upper
);

    logic [HALFWORD_W-1:0] half;

    always_comb begin
        half          = i_sel_upper ? i_entry.word[WORD_W-1:HALFWORD_W]
                                    : i_entry.word[HALFWORD_W-1:0];
        o_instruction = '0;
        o_pc          = i_entry.pc;
        o_upper       = 1'b0;

        if (i_entry.t) begin
            o_upper = i_sel_upper;
            o_pc    = {i_entry.pc[SEQ_PC_W-1:2], i_sel_upper, 1'b0};
            if (!i_entry.abort) begin
                o_instruction = {{(WORD_W-HALFWORD_W){1'b0}}, half};
            end
        end else if (!i_entry.abort) begin
            o_instruction = i_entry.word;
        end
    end

endmodule

// File: rtl/zap_mode16_halfword_sequencer.sv
// ---------------------------------------------------------------------------
// zap_mode16_halfword_sequencer
//
// Sits between instruction fetch and the 16-bit decoder. Each accepted
// 32-bit word becomes one issue in 32-bit mode, or up to two halfword
// issues in compressed mode. Fetch is back-pressured while an upper half
// is still waiting. PC, abort and interrupt status ride along with every
// issue so the decoder sees one tagged instruction per cycle.
//
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_clear                flush; beats stall and issue
//   i_stall                downstream stall; outputs hold
//   i_cpsr_ff_t            T bit, latched per word at accept
//   i_fetch_word/pc/valid  fetch interface (pc[1]=1 => enter at upper half)
//   i_fetch_iabort         instruction abort for the fetched word
//   o_fetch_ready          combinational accept strobe for fetch
//   i_irq, i_fiq           level interrupts, sampled at the issue edge
//   o_instruction/_valid   issued instruction ({16'd0,hw} in T mode)
//   o_pc, o_upper          address of issue, came from bits [31:16]
//   o_iabort, o_irq, o_fiq status attached to this issue only
// ---------------------------------------------------------------------------
module zap_mode16_halfword_sequencer
    import zap_mode16_seq_pkg::*;
#(
    parameter int                PC_W         = 32,
    parameter logic [PC_W-1:0]   RESET_VECTOR = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_stall,
    input  logic              i_cpsr_ff_t,
    input  logic [31:0]       i_fetch_word,
    input  logic [PC_W-1:0]   i_fetch_pc,
    input  logic              i_fetch_valid,
    input  logic              i_fetch_iabort,
    output logic              o_fetch_ready,
    input  logic              i_irq,
    input  logic              i_fiq,
    output logic [31:0]       o_instruction,
    output logic              o_instruction_valid,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_upper,
    output logic              o_iabort,
    output logic              o_irq,
    output logic              o_fiq
);

    seq_state_t state_ff, state_nxt;
    seq_entry_t buf_ff, buf_nxt;

    seq_entry_t fetch_entry;
    seq_state_t fetch_state;
    logic       accept;

    seq_entry_t          issue_entry;
    logic                issue_sel_upper;
    logic                issue_go;
    logic [WORD_W-1:0]   sel_instruction;
    logic [SEQ_PC_W-1:0] sel_pc;
    logic                sel_upper;

    logic [31:0]     instruction_nxt;
    logic            valid_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            upper_nxt;
    logic            iabort_nxt;
    logic            irq_nxt;
    logic            fiq_nxt;

    // A new word may only come in when nothing is buffered, or when the
    // last pending upper half leaves this very cycle.
    assign o_fetch_ready = !i_clear &&
                           ((state_ff == ST_EMPTY) || ((state_ff == ST_HI) && !i_stall));
    assign accept        = o_fetch_ready && i_fetch_valid;

    // Packs the fetch inputs as a buffer entry, and works out where a newly
    // loaded word starts: a T-mode entry at pc[1]=1 skips its lower half.
    always_comb begin
        fetch_entry.word  = i_fetch_word;
        fetch_entry.pc    = SEQ_PC_W'(i_fetch_pc);
        fetch_entry.t     = i_cpsr_ff_t;
        fetch_entry.abort = i_fetch_iabort;
        fetch_state       = (i_cpsr_ff_t && i_fetch_pc[1]) ? ST_HI : ST_LO;
    end

    // Chooses what would issue this cycle. From EMPTY the fetch inputs
    // bypass the buffer so a word issues on the edge that accepts it.
    always_comb begin
        issue_entry     = buf_ff;
        issue_sel_upper = 1'b0;
        issue_go        = 1'b0;
        unique case (state_ff)
            ST_EMPTY: begin
                issue_entry     = fetch_entry;
                issue_sel_upper = i_cpsr_ff_t && i_fetch_pc[1];
                issue_go        = accept;
            end
            ST_LO: begin
                issue_go = 1'b1;
            end
            ST_HI: begin
                issue_sel_upper = 1'b1;
                issue_go        = 1'b1;
            end
            default: begin
                issue_go = 1'b0;
            end
        endcase
    end

    zap_mode16_hw_select u_hw_select (
        .i_entry       (issue_entry),
        .i_sel_upper   (issue_sel_upper),
        .o_instruction (sel_instruction),
        .o_pc          (sel_pc),
        .o_upper       (sel_upper)
    );

    // Next-state and next-output logic. Clear outranks stall, which
    // outranks issue. During a stall the only thing allowed to move is an
    // empty buffer picking up a word.
    always_comb begin
        state_nxt       = state_ff;
        buf_nxt         = buf_ff;
        instruction_nxt = o_instruction;
        valid_nxt       = o_instruction_valid;
        pc_nxt          = o_pc;
        upper_nxt       = o_upper;
        iabort_nxt      = o_iabort;
        irq_nxt         = o_irq;
        fiq_nxt         = o_fiq;

        if (i_clear) begin
            state_nxt  = ST_EMPTY;
            valid_nxt  = 1'b0;
            iabort_nxt = 1'b0;
            irq_nxt    = 1'b0;
            fiq_nxt    = 1'b0;
        end else if (i_stall) begin
            if ((state_ff == ST_EMPTY) && accept) begin
                buf_nxt   = fetch_entry;
                state_nxt = fetch_state;
            end
        end else if (issue_go) begin
            instruction_nxt = sel_instruction;
            valid_nxt       = 1'b1;
            pc_nxt          = PC_W'(sel_pc);
            upper_nxt       = sel_upper;
            iabort_nxt      = issue_entry.abort;
            irq_nxt         = i_irq;
            fiq_nxt         = i_fiq;

            // An abort kills the rest of the word; otherwise a T lower half
            // leaves its upper half pending.
            if (!issue_entry.t || issue_entry.abort || issue_sel_upper) begin
                state_nxt = ST_EMPTY;
            end else begin
                state_nxt = ST_HI;
                buf_nxt   = issue_entry;
            end

            // Upper half leaving while the next word arrives: keep streaming.
            if ((state_ff == ST_HI) && accept) begin
                buf_nxt   = fetch_entry;
                state_nxt = fetch_state;
            end
        end else begin
            valid_nxt  = 1'b0;
            iabort_nxt = 1'b0;
            irq_nxt    = 1'b0;
            fiq_nxt    = 1'b0;
        end
    end

    // State, buffer and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_ff            <= ST_EMPTY;
            buf_ff              <= '0;
            o_instruction       <= '0;
            o_instruction_valid <= 1'b0;
            o_pc                <= RESET_VECTOR;
            o_upper             <= 1'b0;
            o_iabort            <= 1'b0;
            o_irq               <= 1'b0;
            o_fiq               <= 1'b0;
        end else begin
            state_ff            <= state_nxt;
            buf_ff              <= buf_nxt;
            o_instruction       <= instruction_nxt;
            o_instruction_valid <= valid_nxt;
            o_pc                <= pc_nxt;
            o_upper             <= upper_nxt;
            o_iabort            <= iabort_nxt;
            o_irq               <= irq_nxt;
            o_fiq               <= fiq_nxt;
        end
    end

endmodule

// File: tb/tb_zap_mode16_halfword_sequencer.sv
// ---------------------------------------------------------------------------
// tb_zap_mode16_halfword_sequencer
//
// Self-checking bench. The reference model treats the sequencer as a queue
// of pending issues: every accepted word is expanded into the list of
// instructions it will produce, and each unstalled cycle pops one of them.
// ---------------------------------------------------------------------------
module tb_zap_mode16_halfword_sequencer;

    localparam logic [31:0] RV = 32'hFFFF_0000;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_clear, i_stall, i_cpsr_ff_t;
    logic [31:0] i_fetch_word, i_fetch_pc;
    logic        i_fetch_valid, i_fetch_iabort;
    logic        o_fetch_ready;
    logic        i_irq, i_fiq;
    logic [31:0] o_instruction;
    logic        o_instruction_valid;
    logic [31:0] o_pc;
    logic        o_upper, o_iabort, o_irq, o_fiq;

    int checks = 0;
    int errors = 0;

    zap_mode16_halfword_sequencer #(.PC_W(32), .RESET_VECTOR(RV)) dut (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_clear             (i_clear),
        .i_stall             (i_stall),
        .i_cpsr_ff_t         (i_cpsr_ff_t),
        .i_fetch_word        (i_fetch_word),
        .i_fetch_pc          (i_fetch_pc),
        .i_fetch_valid       (i_fetch_valid),
        .i_fetch_iabort      (i_fetch_iabort),
        .o_fetch_ready       (o_fetch_ready),
        .i_irq               (i_irq),
        .i_fiq               (i_fiq),
        .o_instruction       (o_instruction),
        .o_instruction_valid (o_instruction_valid),
        .o_pc                (o_pc),
        .o_upper             (o_upper),
        .o_iabort            (o_iabort),
        .o_irq               (o_irq),
        .o_fiq               (o_fiq)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        upper;
        logic        abort;
    } item_t;

    item_t       pend[$];
    logic        e_valid, e_upper, e_iabort, e_irq, e_fiq;
    logic [31:0] e_instr, e_pc;

    function automatic logic [68:0] exp_bus();
        return {e_valid, e_instr, e_pc, e_upper, e_iabort, e_irq, e_fiq};
    endfunction

    function automatic logic [68:0] dut_bus();
        return {o_instruction_valid, o_instruction, o_pc, o_upper, o_iabort, o_irq, o_fiq};
    endfunction

    function automatic logic model_ready();
        if (i_clear) return 1'b0;
        if (pend.size() == 0) return 1'b1;
        return (pend.size() == 1) && pend[0].upper && !i_stall;
    endfunction

    task automatic model_reset();
        pend.delete();
        {e_valid, e_instr, e_upper, e_iabort, e_irq, e_fiq} = '0;
        e_pc = RV;
    endtask

    // Expands one word into the instructions the decoder should see.
    task automatic model_push(input logic [31:0] w, input logic [31:0] pc,
                              input logic t, input logic ab);
        logic [31:0] base;
        base = {pc[31:2], 2'b00};
        if (!t) begin
            pend.push_back('{instr: ab ? 32'd0 : w, pc: pc, upper: 1'b0, abort: ab});
        end else if (ab) begin
            pend.push_back('{instr: 32'd0, pc: base | {30'd0, pc[1], 1'b0},
                             upper: pc[1], abort: 1'b1});
        end else begin
            if (!pc[1])
                pend.push_back('{instr: {16'd0, w[15:0]}, pc: base, upper: 1'b0, abort: 1'b0});
            pend.push_back('{instr: {16'd0, w[31:16]}, pc: base + 32'd2, upper: 1'b1, abort: 1'b0});
        end
    endtask

    task automatic model_edge();
        logic  acc, had;
        item_t it;
        acc = model_ready() && i_fetch_valid;
        if (i_clear) begin
            pend.delete();
            {e_valid, e_iabort, e_irq, e_fiq} = '0;
        end else if (i_stall) begin
            if (acc) model_push(i_fetch_word, i_fetch_pc, i_cpsr_ff_t, i_fetch_iabort);
        end else begin
            had = (pend.size() != 0);
            if (acc && !had) model_push(i_fetch_word, i_fetch_pc, i_cpsr_ff_t, i_fetch_iabort);
            if (pend.size() != 0) begin
                it = pend.pop_front();
                e_valid = 1'b1; e_instr = it.instr; e_pc = it.pc;
                e_upper = it.upper; e_iabort = it.abort;
                e_irq = i_irq; e_fiq = i_fiq;
                // an aborted word never issues its other half
                if (it.abort) pend.delete();
            end else begin
                {e_valid, e_iabort, e_irq, e_fiq} = '0;
            end
            if (acc && had) model_push(i_fetch_word, i_fetch_pc, i_cpsr_ff_t, i_fetch_iabort);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic clr, input logic stl, input logic t,
                         input logic vld, input logic abt, input logic irq,
                         input logic fiq, input logic [31:0] w, input logic [31:0] pc);
        i_clear = clr; i_stall = stl; i_cpsr_ff_t = t; i_fetch_valid = vld;
        i_fetch_iabort = abt; i_irq = irq; i_fiq = fiq;
        i_fetch_word = w; i_fetch_pc = pc;
    endtask

    task automatic tick();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
            #1;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        model_reset();
        #12;
        checks++;
        if (dut_bus() !== exp_bus()) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", dut_bus(), exp_bus());
        end
        checks++;
        if (o_pc !== RV) begin
            errors++;
            $display("[TB] FAIL reset_pc got %h want %h", o_pc, RV);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();
        checks++;
        if (o_fetch_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b want 1", o_fetch_ready);
        end
    endtask

    task automatic test_thumb_pair();
        logic [31:0] want_i[2] = '{32'h0000_4770, 32'h0000_B510};
        logic [31:0] want_p[2] = '{32'h100, 32'h102};
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive(0, 0, 1, 1, 0, 0, 0, 32'hB510_4770, 32'h100);
            else        drive(0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
            #1;
            checks++;
            if (o_fetch_ready !== model_ready()) begin
                errors++;
                $display("[TB] FAIL thumb_pair_ready c%0d got %b want %b", c, o_fetch_ready, model_ready());
            end
            tick();
            checks++;
            if ({o_instruction_valid, o_instruction, o_pc, o_upper} !==
                {1'b1, want_i[c], want_p[c], c[0]}) begin
                errors++;
                $display("[TB] FAIL thumb_pair_issue c%0d got %h/%h/%b want %h/%h/%b",
                         c, o_instruction, o_pc, o_upper, want_i[c], want_p[c], c[0]);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_upper_entry();
        drive(0, 0, 1, 1, 0, 0, 0, 32'hE7FE_BF00, 32'h202);
        #1;
        tick();
        checks++;
        if ({o_instruction_valid, o_instruction, o_pc, o_upper} !== {1'b1, 32'h0000_E7FE, 32'h202, 1'b1}) begin
            errors++;
            $display("[TB] FAIL upper_entry got %h/%h/%b want 0000e7fe/00000202/1", o_instruction, o_pc, o_upper);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
        #1;
        checks++;
        if (o_fetch_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL upper_entry_ready got %b want 1", o_fetch_ready);
        end
        tick();
        checks++;
        if (dut_bus() !== exp_bus()) begin
            errors++;
            $display("[TB] FAIL upper_entry_after got %h want %h", dut_bus(), exp_bus());
        end
    endtask

    task automatic test_arm_back_to_back();
        logic [31:0] words[2] = '{32'hE3A0_0001, 32'hE280_0001};
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 1, 0, 0, 0, words[c], 32'(c * 4));
            #1;
            checks++;
            if (o_fetch_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL arm_ready c%0d got %b want 1", c, o_fetch_ready);
            end
            tick();
            checks++;
            if ({o_instruction_valid, o_instruction, o_pc, o_upper} !== {1'b1, words[c], 32'(c * 4), 1'b0}) begin
                errors++;
                $display("[TB] FAIL arm_issue c%0d got %h/%h want %h/%h", c, o_instruction, o_pc, words[c], c * 4);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_stall_hold();
        drive(0, 0, 1, 1, 0, 0, 0, 32'hB510_4770, 32'h500);
        #1;
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 1, 1, 0, 1, 0, 32'h1234_5678, 32'h600);
            #1;
            checks++;
            if (o_fetch_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_ready c%0d got %b want 0", c, o_fetch_ready);
            end
            tick();
            checks++;
            if ({o_instruction_valid, o_instruction, o_pc, o_irq} !== {1'b1, 32'h0000_4770, 32'h500, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_hold c%0d got %h/%h/%b", c, o_instruction, o_pc, o_irq);
            end
        end
        drive(0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
        #1;
        tick();
        checks++;
        if ({o_instruction_valid, o_instruction, o_pc, o_upper} !== {1'b1, 32'h0000_B510, 32'h502, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stall_release got %h/%h/%b want 0000b510/00000502/1", o_instruction, o_pc, o_upper);
        end
        idle_cycles(1);
    endtask

    task automatic test_abort();
        drive(0, 0, 1, 1, 1, 0, 0, 32'hB510_4770, 32'h400);
        #1;
        tick();
        checks++;
        if ({o_instruction_valid, o_iabort, o_instruction, o_pc} !== {1'b1, 1'b1, 32'd0, 32'h400}) begin
            errors++;
            $display("[TB] FAIL abort_issue got v%b a%b %h %h", o_instruction_valid, o_iabort, o_instruction, o_pc);
        end
        drive(0, 0, 1, 1, 0, 0, 0, 32'hAAAA_5555, 32'h404);
        #1;
        checks++;
        if (o_fetch_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_next_ready got %b want 1", o_fetch_ready);
        end
        tick();
        checks++;
        if ({o_iabort, o_instruction, o_pc} !== {1'b0, 32'h0000_5555, 32'h404}) begin
            errors++;
            $display("[TB] FAIL abort_next_issue got a%b %h %h want 0 00005555 00000404", o_iabort, o_instruction, o_pc);
        end
        idle_cycles(2);
    endtask

    task automatic test_clear_hi();
        drive(0, 0, 1, 1, 0, 0, 0, 32'hB510_4770, 32'h200);
        #1;
        tick();
        drive(1, 0, 1, 1, 0, 1, 0, 32'h2222_1111, 32'h300);
        #1;
        checks++;
        if (o_fetch_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_ready got %b want 0", o_fetch_ready);
        end
        tick();
        checks++;
        if ({o_instruction_valid, o_irq, o_instruction, o_pc} !== {1'b0, 1'b0, 32'h0000_4770, 32'h200}) begin
            errors++;
            $display("[TB] FAIL clear_outputs got v%b i%b %h %h", o_instruction_valid, o_irq, o_instruction, o_pc);
        end
        drive(0, 0, 1, 1, 0, 0, 0, 32'h2222_1111, 32'h300);
        #1;
        tick();
        checks++;
        if ({o_instruction_valid, o_instruction, o_pc, o_upper} !== {1'b1, 32'h0000_1111, 32'h300, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_next got %h/%h/%b want 00001111/00000300/0", o_instruction, o_pc, o_upper);
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic clr, stl, t, vld, abt, irq, fiq;
        logic [31:0] w, pc;
        for (int c = 0; c < 400; c++) begin
            clr = ($urandom_range(0, 99) < 5);
            stl = ($urandom_range(0, 99) < 25);
            t   = ($urandom_range(0, 99) < 70);
            vld = ($urandom_range(0, 99) < 75);
            abt = ($urandom_range(0, 99) < 10);
            irq = $urandom_range(0, 1) == 1;
            fiq = $urandom_range(0, 1) == 1;
            w   = $urandom();
            pc  = $urandom() & 32'hFFFF_FFFE;
            drive(clr, stl, t, vld, abt, irq, fiq, w, pc);
            #1;
            checks++;
            if (o_fetch_ready !== model_ready()) begin
                errors++;
                $display("[TB] FAIL rand_ready c%0d got %b want %b", c, o_fetch_ready, model_ready());
            end
            tick();
            checks++;
            if (dut_bus() !== exp_bus()) begin
                errors++;
                $display("[TB] FAIL rand_issue c%0d got %h want %h", c, dut_bus(), exp_bus());
            end
        end
        idle_cycles(3);
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1, 1, 0, 1, 0, 32'hB510_4770, 32'h700);
        #1;
        tick();
        drive(0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
        #2;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o_instruction_valid, o_pc} !== {1'b0, RV}) begin
            errors++;
            $display("[TB] FAIL async_reset got v%b pc %h want 0 %h", o_instruction_valid, o_pc, RV);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();
        checks++;
        if (dut_bus() !== exp_bus()) begin
            errors++;
            $display("[TB] FAIL async_reset_after got %h want %h", dut_bus(), exp_bus());
        end
    endtask

    initial begin
        test_reset();
        test_thumb_pair();
        test_upper_entry();
        test_arm_back_to_back();
        test_stall_hold();
        test_abort();
        test_clear_hi();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
